noc_client: RTL and testbench

NOC_CLIENT -- requirements
Module: noc_client

---
 rtl/noc_client.sv | 120 ++++++++++++
 tb/tb_noc_client.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_client.sv
// Traffic-generating NoC endpoint: injects single-flit packets at a programmed
// rate and destination pattern, and counts/validates flits arriving from the tree.
module noc_client #(
    parameter int unsigned N     = 2,
    parameter int unsigned D_W   = 32,
    parameter int unsigned A_W   = $clog2(N) + 1,
    parameter int unsigned posx  = 0,
    parameter int unsigned LIMIT = 1024,
    parameter int unsigned RATE  = 100,
    parameter int unsigned PAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    output logic [A_W+D_W:0] peo,
    output logic             peo_v,
    input  logic             peo_r,
    output logic             peo_l,
    input  logic [A_W+D_W:0] pei,
    input  logic             pei_v,
    output logic             pei_r,
    input  logic             pei_l,
    output logic [31:0]      sent_cnt,
    output logic [31:0]      recv_cnt,
    output logic             err,
    output logic             done
);

    localparam int unsigned DEST_W = $clog2(N);
    localparam int unsigned CHK_W  = A_W - 1;
    localparam int unsigned F_W    = A_W + D_W + 1;
    localparam logic [7:0]  FULL   = 8'd100;
    localparam logic [7:0]  STEP   = 8'(RATE);
    localparam logic [31:0] LIM    = 32'(LIMIT);

    logic [7:0]        acc;
    logic [31:0]       seq;
    logic [31:0]       gen_cnt;
    logic [31:0]       dest_sum_c;
    logic [DEST_W-1:0] dest_c;
    logic [F_W-1:0]    flit_c;
    logic              can_gen_c;
    logic              fire_c;
    logic              xfer_c;
    logic              rx_c;
    logic              rx_bad_c;
    logic              pei_unused;

    // Destination selection; masking with N-1 is plain truncation since N is a power of two.
    always_comb begin
        dest_sum_c = 32'(posx) + 32'd1;
        if (PAT == 1) begin
            dest_sum_c = 32'(N - 1 - posx);
        end else if (PAT == 2) begin
            dest_sum_c = 32'(posx) + seq + 32'd1;
        end
        dest_c = DEST_W'(dest_sum_c);
        flit_c = {A_W'(dest_c), 1'b0, D_W'(seq)};
    end

    // A new flit may be loaded only when the output register is empty or draining this cycle.
    always_comb begin
        can_gen_c = gen_cnt < LIM;
        xfer_c    = peo_v & peo_r;
        fire_c    = ce & (acc >= FULL) & can_gen_c & (~peo_v | peo_r);
        rx_c      = pei_v & pei_r;
        rx_bad_c  = (pei[A_W+D_W-1:D_W+1] != CHK_W'(posx)) | ~pei_l;
    end

    assign pei_unused = ^{pei[A_W+D_W], pei[D_W:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc      <= '0;
            seq      <= '0;
            gen_cnt  <= '0;
            sent_cnt <= '0;
            recv_cnt <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
            peo      <= '0;
            peo_v    <= 1'b0;
            peo_l    <= 1'b0;
            pei_r    <= 1'b0;
        end else begin
            pei_r <= 1'b1;
            if (fire_c) begin
                peo     <= flit_c;
                peo_v   <= 1'b1;
                peo_l   <= 1'b1;
                seq     <= seq + 32'd1;
                gen_cnt <= gen_cnt + 32'd1;
                acc     <= acc - FULL + STEP;
            end else begin
                if (xfer_c) begin
                    peo_v <= 1'b0;
                    peo_l <= 1'b0;
                end
                if (ce && (acc < FULL) && can_gen_c) begin
                    acc <= acc + STEP;
                end
            end
            if (xfer_c && (sent_cnt != '1)) begin
                sent_cnt <= sent_cnt + 32'd1;
            end
            if (rx_c) begin
                if (recv_cnt != '1) begin
                    recv_cnt <= recv_cnt + 32'd1;
                end
                if (rx_bad_c) begin
                    err <= 1'b1;
                end
            end
            if ((gen_cnt == LIM) && (sent_cnt == LIM)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_client.sv
// Bench for noc_client: three instances cover streaming, rate limiting, receive
// checking, back-pressure with random ce/ready, and reset during a handshake.
module tb_noc_client;

    localparam int unsigned NN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    logic        rst_a = 0, ce_a = 0, peo_v_a, peo_r_a = 0, peo_l_a, pei_v_a = 0, pei_r_a, pei_l_a = 0;
    logic        err_a, done_a;
    logic [35:0] peo_a, pei_a = '0;
    logic [31:0] sent_a, recv_a;

    logic        rst_b = 0, ce_b = 0, peo_v_b, peo_r_b = 0, peo_l_b, pei_v_b = 0, pei_r_b, pei_l_b = 0;
    logic        err_b, done_b;
    logic [35:0] peo_b, pei_b = '0;
    logic [31:0] sent_b, recv_b;

    logic        rst_c = 0, ce_c = 0, peo_v_c, peo_r_c = 0, peo_l_c, pei_v_c = 0, pei_r_c, pei_l_c = 0;
    logic        err_c, done_c;
    logic [35:0] peo_c, pei_c = '0;
    logic [31:0] sent_c, recv_c;

    int c_next = 0;
    int c_sent = 0;

    noc_client #(.N(4), .posx(1), .PAT(0), .RATE(100), .LIMIT(8)) dut_a (
        .clk(clk), .rst(rst_a), .ce(ce_a), .peo(peo_a), .peo_v(peo_v_a), .peo_r(peo_r_a),
        .peo_l(peo_l_a), .pei(pei_a), .pei_v(pei_v_a), .pei_r(pei_r_a), .pei_l(pei_l_a),
        .sent_cnt(sent_a), .recv_cnt(recv_a), .err(err_a), .done(done_a));

    noc_client #(.N(4), .posx(2), .PAT(1), .RATE(50), .LIMIT(4)) dut_b (
        .clk(clk), .rst(rst_b), .ce(ce_b), .peo(peo_b), .peo_v(peo_v_b), .peo_r(peo_r_b),
        .peo_l(peo_l_b), .pei(pei_b), .pei_v(pei_v_b), .pei_r(pei_r_b), .pei_l(pei_l_b),
        .sent_cnt(sent_b), .recv_cnt(recv_b), .err(err_b), .done(done_b));

    noc_client #(.N(4), .posx(0), .PAT(2), .RATE(100), .LIMIT(1000)) dut_c (
        .clk(clk), .rst(rst_c), .ce(ce_c), .peo(peo_c), .peo_v(peo_v_c), .peo_r(peo_r_c),
        .peo_l(peo_l_c), .pei(pei_c), .pei_v(pei_v_c), .pei_r(pei_r_c), .pei_l(pei_l_c),
        .sent_cnt(sent_c), .recv_cnt(recv_c), .err(err_c), .done(done_c));

    // Expected flit number k for an endpoint: address field holds dest, payload holds k.
    function automatic logic [35:0] exp_flit(input int unsigned px, input int unsigned pat,
                                             input int unsigned k);
        int unsigned dest;
        if (pat == 0)      dest = (px + 1) % NN;
        else if (pat == 1) dest = NN - 1 - px;
        else               dest = (px + k + 1) % NN;
        return (36'(dest) << 33) | 36'(k);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vec++;
        if ({peo_a, peo_v_a, peo_l_a, pei_r_a, sent_a, recv_a, err_a, done_a} !== '0) begin
            errs++; $display("FAIL reset_a: outputs not all zero, peo=%h v=%b", peo_a, peo_v_a);
        end
        vec++;
        if ({peo_b, peo_v_b, peo_l_b, pei_r_b, sent_b, recv_b, err_b, done_b} !== '0) begin
            errs++; $display("FAIL reset_b: outputs not all zero, peo=%h v=%b", peo_b, peo_v_b);
        end
        vec++;
        if ({peo_c, peo_v_c, peo_l_c, pei_r_c, sent_c, recv_c, err_c, done_c} !== '0) begin
            errs++; $display("FAIL reset_c: outputs not all zero, peo=%h v=%b", peo_c, peo_v_c);
        end
    endtask

    task automatic test_stream();
        int exp_sent;
        logic exp_v;
        rst_a = 1; ce_a = 1; peo_r_a = 1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_v    = (c >= 2) && (c <= 9);
            exp_sent = (c <= 2) ? 0 : ((c - 2 > 8) ? 8 : c - 2);
            vec++;
            if (peo_v_a !== exp_v) begin
                errs++; $display("FAIL stream_valid c=%0d: got %b want %b", c, peo_v_a, exp_v);
            end
            vec++;
            if (peo_l_a !== exp_v) begin
                errs++; $display("FAIL stream_last c=%0d: got %b want %b", c, peo_l_a, exp_v);
            end
            if (exp_v) begin
                vec++;
                if (peo_a !== exp_flit(1, 0, c - 2)) begin
                    errs++; $display("FAIL stream_flit c=%0d: got %h want %h", c, peo_a, exp_flit(1, 0, c - 2));
                end
            end
            vec++;
            if (sent_a !== 32'(exp_sent)) begin
                errs++; $display("FAIL stream_sent c=%0d: got %0d want %0d", c, sent_a, exp_sent);
            end
            if (c == 1) begin
                vec++;
                if (pei_r_a !== 1'b1) begin
                    errs++; $display("FAIL stream_pei_r: got %b want 1", pei_r_a);
                end
            end
            if (c <= 9) begin
                vec++;
                if (done_a !== 1'b0) begin
                    errs++; $display("FAIL stream_done_early c=%0d: got %b want 0", c, done_a);
                end
            end
        end
        vec++;
        if (done_a !== 1'b1) begin
            errs++; $display("FAIL stream_done: got %b want 1", done_a);
        end
    endtask

    task automatic test_rate();
        int k = 0;
        logic exp_v;
        rst_b = 1; ce_b = 1; peo_r_b = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp_v = (c >= 3) && (c <= 9) && (c % 2 == 1);
            vec++;
            if (peo_v_b !== exp_v) begin
                errs++; $display("FAIL rate_valid c=%0d: got %b want %b", c, peo_v_b, exp_v);
            end
            if (peo_v_b === 1'b1) begin
                vec++;
                if (peo_b !== exp_flit(2, 1, k)) begin
                    errs++; $display("FAIL rate_flit k=%0d: got %h want %h", k, peo_b, exp_flit(2, 1, k));
                end
                k++;
            end
        end
        vec++;
        if (sent_b !== 32'd4) begin
            errs++; $display("FAIL rate_sent: got %0d want 4", sent_b);
        end
        vec++;
        if (done_b !== 1'b1) begin
            errs++; $display("FAIL rate_done: got %b want 1", done_b);
        end
    endtask

    task automatic test_recv();
        logic [2:0] addr;
        for (int i = 0; i < 4; i++) begin
            addr = (i < 3) ? 3'd2 : 3'd3;
            pei_b = {addr, 1'b0, 32'($urandom)};
            pei_v_b = 1; pei_l_b = 1;
            tick();
            vec++;
            if (recv_b !== 32'(i + 1)) begin
                errs++; $display("FAIL recv_cnt i=%0d: got %0d want %0d", i, recv_b, i + 1);
            end
            vec++;
            if (err_b !== (i == 3)) begin
                errs++; $display("FAIL recv_err i=%0d: got %b want %b", i, err_b, i == 3);
            end
        end
        pei_v_b = 0;
    endtask

    task automatic test_recv_random();
        int   cnt = 0;
        logic bad = 0;
        logic [1:0] d;
        rst_b = 0; pei_v_b = 1; pei_l_b = 1;
        repeat (3) tick();
        vec++;
        if ({recv_b, pei_r_b, err_b} !== '0) begin
            errs++; $display("FAIL recv_in_reset: recv=%0d pei_r=%b err=%b want 0", recv_b, pei_r_b, err_b);
        end
        pei_v_b = 0; rst_b = 1; ce_b = 0;
        tick();
        vec++;
        if (pei_r_b !== 1'b1) begin
            errs++; $display("FAIL recv_ready: got %b want 1", pei_r_b);
        end
        for (int i = 0; i < 24; i++) begin
            d       = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd2;
            pei_v_b = 1'($urandom);
            pei_l_b = ($urandom_range(0, 7) != 0);
            pei_b   = {1'b0, d, 1'b0, 32'($urandom)};
            if (pei_v_b) begin
                cnt++;
                if (d != 2'd2 || !pei_l_b) bad = 1;
            end
            tick();
            vec++;
            if (recv_b !== 32'(cnt) || err_b !== bad) begin
                errs++; $display("FAIL recv_rand i=%0d: recv=%0d err=%b want %0d %b", i, recv_b, err_b, cnt, bad);
            end
        end
        pei_v_b = 0;
    endtask

    task automatic test_backpressure();
        logic [35:0] held;
        rst_c = 1; ce_c = 1; peo_r_c = 0;
        tick(); tick();
        vec++;
        if (peo_v_c !== 1'b1 || peo_c !== exp_flit(0, 2, 0)) begin
            errs++; $display("FAIL bp_first: v=%b peo=%h want 1 %h", peo_v_c, peo_c, exp_flit(0, 2, 0));
        end
        held = peo_c;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++;
            if (peo_v_c !== 1'b1 || peo_c !== held || sent_c !== 32'd0) begin
                errs++; $display("FAIL bp_hold i=%0d: v=%b peo=%h sent=%0d want 1 %h 0", i, peo_v_c, peo_c, sent_c, held);
            end
        end
        peo_r_c = 1;
        tick();
        peo_r_c = 0;
        vec++;
        if (sent_c !== 32'd1) begin
            errs++; $display("FAIL bp_release: sent=%0d want 1", sent_c);
        end
        tick();
        vec++;
        if (sent_c !== 32'd1) begin
            errs++; $display("FAIL bp_single: sent=%0d want 1", sent_c);
        end
        c_next = 1; c_sent = 1;
    endtask

    task automatic test_random();
        logic pv = 1, pr = 0, pce = 1;
        logic [35:0] pp = peo_c;
        for (int i = 0; i < 300; i++) begin
            vec++;
            if (peo_l_c !== peo_v_c) begin
                errs++; $display("FAIL rnd_last i=%0d: l=%b v=%b", i, peo_l_c, peo_v_c);
            end
            if (pv && !pr) begin
                vec++;
                if (peo_v_c !== 1'b1 || peo_c !== pp) begin
                    errs++; $display("FAIL rnd_stable i=%0d: v=%b peo=%h want 1 %h", i, peo_v_c, peo_c, pp);
                end
            end else begin
                vec++;
                if (peo_v_c !== pce) begin
                    errs++; $display("FAIL rnd_gen i=%0d: v=%b want %b", i, peo_v_c, pce);
                end
            end
            if (peo_v_c) begin
                vec++;
                if (peo_c !== exp_flit(0, 2, c_next)) begin
                    errs++; $display("FAIL rnd_flit i=%0d: got %h want %h", i, peo_c, exp_flit(0, 2, c_next));
                end
            end
            pv = peo_v_c; pp = peo_c;
            pr  = 1'($urandom);
            pce = ($urandom_range(0, 3) != 0);
            peo_r_c = pr; ce_c = pce;
            if (pv && pr) begin
                c_next++; c_sent++;
            end
            tick();
            vec++;
            if (sent_c !== 32'(c_sent)) begin
                errs++; $display("FAIL rnd_sent i=%0d: got %0d want %0d", i, sent_c, c_sent);
            end
        end
    endtask

    task automatic test_reset_mid();
        ce_c = 1; peo_r_c = 0;
        tick();
        vec++;
        if (peo_v_c !== 1'b1) begin
            errs++; $display("FAIL mid_pending: v=%b want 1", peo_v_c);
        end
        rst_c = 0;
        tick();
        vec++;
        if ({peo_c, peo_v_c, peo_l_c, pei_r_c, sent_c, recv_c, err_c, done_c} !== '0) begin
            errs++; $display("FAIL mid_reset: peo=%h v=%b sent=%0d want all zero", peo_c, peo_v_c, sent_c);
        end
        rst_c = 1; peo_r_c = 1;
        tick(); tick();
        vec++;
        if (peo_v_c !== 1'b1 || peo_c !== exp_flit(0, 2, 0) || sent_c !== 32'd0) begin
            errs++; $display("FAIL mid_restart: v=%b peo=%h sent=%0d want 1 %h 0", peo_v_c, peo_c, sent_c, exp_flit(0, 2, 0));
        end
        tick();
        vec++;
        if (peo_c !== exp_flit(0, 2, 1) || sent_c !== 32'd1) begin
            errs++; $display("FAIL mid_second: peo=%h sent=%0d want %h 1", peo_c, sent_c, exp_flit(0, 2, 1));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rate();
        test_recv();
        test_recv_random();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
